// File: rtl/serial_subtractor16_if.sv
// Operand/result bundle for the bit-serial subtractor.
interface serial_subtractor16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] diff;
  logic             Bout;
  logic             V;
  logic             Z;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Bin,
    input  diff, Bout, V, Z, busy, done
  );

  modport slave (
    input  start, A, B, Bin,
    output diff, Bout, V, Z, busy, done
  );
endinterface

// File: rtl/serial_subtractor16.sv
// Bit-serial subtractor: computes A - B - Bin one bit per cycle, LSB first.
module serial_subtractor16 #(
  parameter int unsigned WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  serial_subtractor16_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_br;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_v;
  logic             r_z;
  logic             r_busy;
  logic             r_done;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_br_next;

  // One full-subtractor cell applied to the current bit position
  assign w_a_bit   = r_a[r_cnt];
  assign w_b_bit   = r_b[r_cnt];
  assign w_d       = w_a_bit ^ w_b_bit ^ r_br;
  assign w_br_next = (~w_a_bit & w_b_bit) | (~w_a_bit & r_br) | (w_b_bit & r_br);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST_BIT) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, bit counter, running borrow and partial-result shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sh  <= '0;
      r_cnt <= '0;
      r_br  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_cnt <= '0;
            r_br  <= bus.Bin;
          end
        end
        SHIFT: begin
          r_sh  <= {w_d, r_sh[WIDTH-1:1]};
          r_cnt <= CW'(r_cnt + 1'b1);
          r_br  <= w_br_next;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; results publish only from DONE so partial shifts stay hidden
  always_ff @(posedge clk) begin
    if (reset) begin
      r_diff <= '0;
      r_bout <= 1'b0;
      r_v    <= 1'b0;
      r_z    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == SHIFT);
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_diff <= r_sh;
        r_bout <= r_br;
        r_v    <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ r_sh[WIDTH-1]);
        r_z    <= (r_sh == '0);
      end
    end
  end

  assign bus.diff = r_diff;
  assign bus.Bout = r_bout;
  assign bus.V    = r_v;
  assign bus.Z    = r_z;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_serial_subtractor16.sv
// Scoreboard bench for serial_subtractor16: random and directed subtractions vs an arithmetic model.
module tb_serial_subtractor16;

  localparam int unsigned W = 16;
  localparam int LATENCY = W + 1;
  localparam int SMAX = (2 ** (W - 1)) - 1;
  localparam int SMIN = -(2 ** (W - 1));

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    logic         z;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  logic [W-1:0] last_d;
  logic         last_bo, last_v, last_z;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor16_if #(.WIDTH(W)) u_if ();

  serial_subtractor16 #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: plain unsigned and signed integer subtraction
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t             e;
    logic [W:0]       full;
    logic signed [W-1:0] sa, sb;
    int               s;
    full = {1'b0, a} - {1'b0, b} - (W + 1)'(bin);
    sa   = a;
    sb   = b;
    s    = int'(sa) - int'(sb) - int'(bin);
    e.d   = full[W-1:0];
    e.bo  = full[W];
    e.v   = (s > SMAX) || (s < SMIN);
    e.z   = (full[W-1:0] == '0);
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: pop on each done pulse; otherwise results must hold
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (u_if.done) begin
          chk("busy_during_done", 64'(u_if.busy), 64'(0));
          if (q.size() == 0) begin
            chk("unexpected_done", 64'(1), 64'(0));
          end else begin
            e = q.pop_front();
            chk("diff", 64'(u_if.diff), 64'(e.d));
            chk("Bout", 64'(u_if.Bout), 64'(e.bo));
            chk("V", 64'(u_if.V), 64'(e.v));
            chk("Z", 64'(u_if.Z), 64'(e.z));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            last_d  = e.d;
            last_bo = e.bo;
            last_v  = e.v;
            last_z  = e.z;
          end
        end else begin
          chk("result_hold", 64'({u_if.diff, u_if.Bout, u_if.V, u_if.Z}),
              64'({last_d, last_bo, last_v, last_z}));
        end
      end
    end
  endtask

  // Present an operation and wait for its acceptance (busy rising); returns just after the accepting edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit hold, output int acc_cyc);
    logic prev;
    bit   accepted;
    exp_t e;
    u_if.A     = a;
    u_if.B     = b;
    u_if.Bin   = bin;
    u_if.start = 1'b1;
    prev       = u_if.busy;
    accepted   = 1'b0;
    acc_cyc    = -1;
    for (int i = 0; i < 60 && !accepted; i++) begin
      @(posedge clk);
      #1;
      if (u_if.busy && !prev) accepted = 1'b1;
      prev = u_if.busy;
    end
    if (!accepted) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: start not accepted, got busy=%0b expected 1", u_if.busy);
    end else begin
      acc_cyc = cyc;
      e       = model(a, b, bin);
      e.cyc   = cyc + LATENCY;
      q.push_back(e);
    end
    if (!hold) u_if.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  logic [W-1:0] da[5] = '{16'd10, 16'h8000, 16'h7FFF, 16'h1234, 16'h0000};
  logic [W-1:0] db[5] = '{16'd100, 16'h0001, 16'hFFFF, 16'h1234, 16'h0000};
  logic         dbin[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] corner[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

  initial begin
    int acc, c0, bcnt;
    logic [W-1:0] ra, rb;
    bit hold;

    reset      = 1'b1;
    u_if.start = 1'b0;
    u_if.A     = '0;
    u_if.B     = '0;
    u_if.Bin   = 1'b0;
    last_d = '0; last_bo = 1'b0; last_v = 1'b0; last_z = 1'b0;
    fork
      monitor();
    join_none

    // Reset state, with start asserted to confirm reset priority
    u_if.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    u_if.start = 1'b0;
    chk("rst_diff", 64'(u_if.diff), 64'(0));
    chk("rst_Bout", 64'(u_if.Bout), 64'(0));
    chk("rst_V", 64'(u_if.V), 64'(0));
    chk("rst_Z", 64'(u_if.Z), 64'(0));
    chk("rst_busy", 64'(u_if.busy), 64'(0));
    chk("rst_done", 64'(u_if.done), 64'(0));
    reset  = 1'b0;
    mon_en = 1'b1;

    // First operation: accepted on the first edge, busy for exactly W cycles
    c0 = cyc;
    run_op(16'd100, 16'd10, 1'b0, 1'b0, acc);
    chk("first_accept_edge", 64'(acc), 64'(c0 + 1));
    bcnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (u_if.busy) bcnt++;
      else break;
    end
    chk("busy_cycles", 64'(bcnt), 64'(W));
    drain();

    // Directed boundary operands
    for (int i = 0; i < 5; i++) begin
      run_op(da[i], db[i], dbin[i], 1'b0, acc);
      drain();
    end

    // Second start mid-SHIFT is ignored and does not queue
    run_op(16'h4321, 16'h0123, 1'b1, 1'b0, acc);
    repeat (5) @(posedge clk);
    #1;
    u_if.A = 16'hFFFF; u_if.B = 16'h0000; u_if.Bin = 1'b0; u_if.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    u_if.start = 1'b0;
    drain();
    repeat (25) @(posedge clk);
    #1;

    // Reset during SHIFT aborts with no done pulse
    run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, acc);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(u_if.busy), 64'(0));
    chk("abort_done", 64'(u_if.done), 64'(0));
    chk("abort_outputs", 64'({u_if.diff, u_if.Bout, u_if.V, u_if.Z}), 64'(0));
    q.delete();
    last_d = '0; last_bo = 1'b0; last_v = 1'b0; last_z = 1'b0;
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    run_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, acc);
    drain();

    // Random regression, mostly back-to-back with start held high
    for (int n = 0; n < 2500; n++) begin
      ra   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      if ($urandom_range(0, 15) == 0) rb = ra;
      hold = ($urandom_range(0, 3) != 0);
      run_op(ra, rb, 1'($urandom_range(0, 1)), hold, acc);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    u_if.start = 1'b0;
    drain();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
